bus_xfr_tx: RTL

Transmit end of the bus transfer path. It takes a burst of words from an upstream valid/ready source and drives write strobes and write data into the transfer buffer. It also tracks buffer occupancy from the reader's pop notifications, so it never writes to a full buffer and never under-counts on read. Single clock domain; it sits between the packet source and the write port of the buffer that the integrity checker monitors.

---
 rtl/bus_xfr_tx.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/bus_xfr_tx.sv
// ---------------------------------------------------------------------------
// bus_xfr_tx
//
// Transmit end of the bus transfer path. Accepts a burst of words from an
// upstream valid/ready source and turns each accepted word into a registered
// write strobe plus write data for the transfer buffer. Buffer occupancy is
// tracked here from the reader's pop notifications, so a write is never
// issued into a full buffer.
//
// Optional feature macro: XFR_CHKSUM_EN
//   When defined, the burst payload is summed modulo 2^DATA_W and one extra
//   write carrying that sum follows the last payload word.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      burst start pulse, only looked at while idle
//   len        burst length in words, sampled with start
//   busy       high while a burst is in progress
//   done       one-cycle pulse with the final write of a burst
//   src_valid  upstream word valid
//   src_data   upstream word
//   src_ready  combinational ready back to the source
//   wr         registered buffer write strobe
//   wdata      registered buffer write data (holds when wr=0)
//   rd_done    reader popped one word this cycle
//   occupancy  words written and not yet popped
//   full       occupancy has reached MAX_BUFF_SIZE
//   rd_err     sticky: a pop was reported while the buffer was empty
// ---------------------------------------------------------------------------
module bus_xfr_tx #(
  parameter  int DATA_W        = 32,
  parameter  int MAX_BUFF_SIZE = 1024,
  parameter  int LEN_W         = 16,
  localparam int CNT_W         = $clog2(MAX_BUFF_SIZE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              wr,
  output logic [DATA_W-1:0] wdata,
  input  logic              rd_done,
  output logic [CNT_W-1:0]  occupancy,
  output logic              full,
  output logic              rd_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
`ifdef XFR_CHKSUM_EN
  localparam logic [1:0] CHK  = 2'd2;
`endif

  localparam logic [CNT_W-1:0] MAX_OCC = CNT_W'(MAX_BUFF_SIZE);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              full_q, full_d;
  logic              rderr_q, rderr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic has_room;
  logic hs;
  logic push;
  logic pop;

  // Room is judged on the counter, which already includes the word that is
  // in the output register, so ready never over-commits the buffer.
  assign has_room  = (occ_q < MAX_OCC);
  assign src_ready = (state_q == SEND) && has_room;
  assign hs        = src_valid && src_ready;
  assign pop       = rd_done && (occ_q != '0);

`ifdef XFR_CHKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              chk_issue;

  assign chk_issue = (state_q == CHK) && has_room;
  assign push      = hs || chk_issue;
`else
  assign push      = hs;
`endif

  // Burst sequencing: latch the length, count handshakes down, and decide
  // where the final word (or the checksum word) ends the burst.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
`ifdef XFR_CHKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = SEND;
            remaining_d = len;
`ifdef XFR_CHKSUM_EN
            sum_d       = '0;
`endif
          end
        end
      end
      SEND: begin
        if (hs) begin
          remaining_d = remaining_q - LEN_ONE;
          wdata_d     = src_data;
`ifdef XFR_CHKSUM_EN
          sum_d       = sum_q + src_data;
          if (remaining_q == LEN_ONE) begin
            state_d = CHK;
          end
`else
          if (remaining_q == LEN_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`endif
        end
      end
`ifdef XFR_CHKSUM_EN
      CHK: begin
        if (chk_issue) begin
          wdata_d = sum_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Occupancy bookkeeping: a push and a pop in the same cycle cancel, and a
  // pop reported against an empty buffer is dropped but remembered.
  always_comb begin
    wr_d    = push;
    busy_d  = (state_d != IDLE);
    occ_d   = occ_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    full_d  = (occ_d == MAX_OCC);
    rderr_d = rderr_q || (rd_done && (occ_q == '0));
  end

  // All state registers; reset abandons any burst without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      occ_q       <= '0;
      full_q      <= 1'b0;
      rderr_q     <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef XFR_CHKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      occ_q       <= occ_d;
      full_q      <= full_d;
      rderr_q     <= rderr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef XFR_CHKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wr        = wr_q;
  assign wdata     = wdata_q;
  assign occupancy = occ_q;
  assign full      = full_q;
  assign rd_err    = rderr_q;

endmodule
